pvp_bullet_ctrl: RTL and testbench
==================================

Name: pvp_bullet_ctrl

Overview:
- Per-player projectile engine; one instance per player.
- Sits directly upstream of the PvP collision checker: drives its bullet X/Y and active inputs, and consumes that player's hit-on-opponent flag to retire the bullet.
- Handles fire-button edge detection, spawn at player centre, per-frame motion in a latched direction, screen-edge retirement and post-shot cooldown.

Parameters:
- PLAYER_SIZE, 16, player sprite edge in pixels; the spawn offset is PLAYER_SIZE/2.
- SCREEN_W, 640, visible width in pixels; valid X is 0..SCREEN_W-1.
- SCREEN_H, 480, visible height in pixels; valid Y is 0..SCREEN_H-1.
- SPEED, 4, pixels moved per frame_tick; must be at least 1.
- COOLDOWN_FRAMES, 8, frame_ticks spent in COOLDOWN after a bullet retires; range 0..255.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (vsync-derived).
- fire  in  1  player fire button, already synchronised and debounced, level.
- playerX  in  10  owning player's top-left X.
- playerY  in  10  owning player's top-left Y.
- facing  in  2  owning player's direction: 0=up, 1=right, 2=down, 3=left.
- hit  in  1  bullet struck the opponent (from the collision stage); level.
- bulletX  out  10  bullet X.
- bulletY  out  10  bullet Y.
- bullet_active  out  1  bullet is live and must be drawn and collision-checked.
- shot_fired  out  1  one-cycle pulse on spawn (sound and stats hook).

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - bulletX=0, bulletY=0, bullet_active=0, shot_fired=0.
  - state=READY, cooldown counter=0, latched direction=0.
  - fire_prev=1, so a button held through reset does not fire.
- fire_rise = fire & ~fire_prev; fire_prev is registered every cycle.
- READY:
  - On fire_rise, the next cycle has:
    - bulletX = playerX + PLAYER_SIZE/2 and bulletY = playerY + PLAYER_SIZE/2, truncated to 10 bits.
    - facing latched; bullet_active=1; shot_fired=1 for exactly that cycle.
    - state → FLYING.
  - frame_tick has no effect in READY.
- FLYING, evaluated in priority order:
  1. hit=1: bullet_active=0 next cycle, state → COOLDOWN. Position is held, not cleared. hit wins over a simultaneous frame_tick.
  2. frame_tick=1: step by SPEED in the latched direction. Compare in 11-bit arithmetic so there is no wrap.
     - Left exits when bulletX < SPEED.
     - Right exits when bulletX + SPEED > SCREEN_W-1.
     - Up exits when bulletY < SPEED.
     - Down exits when bulletY + SPEED > SCREEN_H-1.
     - On exit: bullet_active=0, position held, state → COOLDOWN. Otherwise update the position; it is always in range.
  3. fire and facing changes are ignored while FLYING; direction is fixed at spawn.
- COOLDOWN:
  - Counter is loaded with COOLDOWN_FRAMES on entry.
  - Decrements on each frame_tick.
  - When it is 0 at a frame_tick, or on entry when COOLDOWN_FRAMES=0, state → READY on the next cycle.
  - A fire_rise during COOLDOWN is discarded, not queued.
- Output timing:
  - bullet_active, bulletX and bulletY are registered.
  - There is exactly one cycle of latency from the triggering event (fire_rise, frame_tick, hit) to the output change.
- Reset mid-flight immediately kills the bullet (bullet_active=0 asynchronously).
- hit asserted while not FLYING is ignored.

Optional Feature:
- Macro: PVP_BULLET_AUTOFIRE_EN.
- Defined:
  - In READY, a fire level (not just a rise) spawns a bullet, so a held button re-fires as soon as COOLDOWN ends.
  - fire_prev still resets to 1, so the first shot after reset still needs a release-press.
- Undefined: only fire_rise spawns; a held button never re-fires.

Decomposition:
- Shared package pvp_pkg holds:
  - typedef dir_t (UP, RIGHT, DOWN, LEFT; 2 bits).
  - typedef bullet_state_t (READY, FLYING, COOLDOWN).
  - Constants SCREEN_W, SCREEN_H, PLAYER_SIZE, which the collision stage also imports.
- One sub-module is natural: pvp_bullet_step. It is combinational: position, direction and SPEED in; next position and exit flag out. It is reusable by a future enemy projectile.
- The FSM, cooldown counter and edge detector stay in the top module.

Test Plan:
- Spawn and step:
  - Stimulus: reset, fire released, then fire pulsed with playerX=100, playerY=200, facing=1 (right).
  - Required: the next cycle has bulletX=108, bulletY=208, bullet_active=1 and a single-cycle shot_fired.
  - After 3 frame_ticks: bulletX=120, bulletY=208.
- Right-edge exit:
  - Stimulus: a right-facing bullet at X=636 (SCREEN_W=640, SPEED=4), then a frame_tick.
  - Required: bullet_active=0 next cycle, bulletX stays 636.
  - With COOLDOWN_FRAMES=8: no spawn is possible until 9 frame_ticks have elapsed.
- Left-edge exit:
  - Stimulus: a left-facing bullet at X=3, then a frame_tick.
  - Required: bullet_active=0 and no wrap to a value near 1023.
- Hit priority:
  - Stimulus: hit and frame_tick asserted in the same cycle while FLYING at X=300.
  - Required: bullet_active=0, bulletX stays 300, state is COOLDOWN.
- Fire gating:
  - Stimulus 1: fire held high through reset release. Required: no spawn.
  - Stimulus 2: a fire_rise during COOLDOWN. Required: no spawn after cooldown.
  - Stimulus 3 (autofire build only): fire held continuously. Required: the next shot_fired arrives the cycle after READY is re-entered.
- Reset mid-flight:
  - Stimulus: rst_n pulled low asynchronously while FLYING at (400, 100).
  - Required: all outputs are 0 without waiting for a clk edge, and the state is READY after release.

Source files
------------

// File: rtl/pvp_pkg.sv
// Shared PvP definitions: screen geometry, sprite size, direction and bullet state encodings.
// Imported by the bullet engine and by the collision stage.
package pvp_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int PLAYER_SIZE = 16;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } bullet_state_t;

endpackage

// File: rtl/pvp_bullet_step.sv
// Projectile single-step: next position plus screen-exit flag for one move of SPEED pixels.
// Latency: combinational. Backpressure: none.
// Exit tests use 11-bit arithmetic so a move never wraps through 0 or 1023.
module pvp_bullet_step
  import pvp_pkg::*;
#(
  parameter int SPEED = 4,
  parameter int X_MAX = pvp_pkg::SCREEN_W - 1,
  parameter int Y_MAX = pvp_pkg::SCREEN_H - 1
) (
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  dir_t       dir,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       exit_flag
);

  localparam logic [10:0] SPD11  = 11'(SPEED);
  localparam logic [9:0]  SPD10  = 10'(SPEED);
  localparam logic [10:0] X_LIM  = 11'(X_MAX);
  localparam logic [10:0] Y_LIM  = 11'(Y_MAX);

  always_comb begin
    next_x    = pos_x;
    next_y    = pos_y;
    exit_flag = 1'b0;
    unique case (dir)
      UP: begin
        exit_flag = ({1'b0, pos_y} < SPD11);
        next_y    = pos_y - SPD10;
      end
      RIGHT: begin
        exit_flag = (({1'b0, pos_x} + SPD11) > X_LIM);
        next_x    = pos_x + SPD10;
      end
      DOWN: begin
        exit_flag = (({1'b0, pos_y} + SPD11) > Y_LIM);
        next_y    = pos_y + SPD10;
      end
      LEFT: begin
        exit_flag = ({1'b0, pos_x} < SPD11);
        next_x    = pos_x - SPD10;
      end
      default: exit_flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/pvp_bullet_ctrl.sv
// Per-player bullet engine: fire edge detect, spawn at player centre, motion, edge/hit retire, cooldown.
// Latency: one cycle from fire_rise/frame_tick/hit to registered outputs. Backpressure: none.
// PVP_BULLET_AUTOFIRE_EN: a held fire level re-spawns in READY once armed by a release after reset.
module pvp_bullet_ctrl
  import pvp_pkg::dir_t, pvp_pkg::bullet_state_t, pvp_pkg::READY, pvp_pkg::FLYING, pvp_pkg::COOLDOWN;
#(
  parameter int PLAYER_SIZE     = pvp_pkg::PLAYER_SIZE,
  parameter int SCREEN_W        = pvp_pkg::SCREEN_W,
  parameter int SCREEN_H        = pvp_pkg::SCREEN_H,
  parameter int SPEED           = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] playerX,
  input  logic [9:0] playerY,
  input  logic [1:0] facing,
  input  logic       hit,
  output logic [9:0] bulletX,
  output logic [9:0] bulletY,
  output logic       bullet_active,
  output logic       shot_fired
);

  localparam logic [9:0] HALF    = 10'(PLAYER_SIZE / 2);
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);

  bullet_state_t state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [7:0]    cd_q, cd_d;
  logic          fire_prev;
  logic          fire_rise;
  logic          spawn_req;
  logic [9:0]    x_d, y_d;
  logic          act_d, shot_d;
  logic [9:0]    step_x, step_y;
  logic          step_exit;

  assign fire_rise = fire & ~fire_prev;

`ifdef PVP_BULLET_AUTOFIRE_EN
  // Cleared by reset so a button held through reset must be released once before any shot.
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (!fire) begin
      armed_q <= 1'b1;
    end
  end

  assign spawn_req = fire & armed_q;
`else
  assign spawn_req = fire_rise;
`endif

  pvp_bullet_step #(
    .SPEED (SPEED),
    .X_MAX (SCREEN_W - 1),
    .Y_MAX (SCREEN_H - 1)
  ) u_step (
    .pos_x     (bulletX),
    .pos_y     (bulletY),
    .dir       (dir_q),
    .next_x    (step_x),
    .next_y    (step_y),
    .exit_flag (step_exit)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cd_d    = cd_q;
    x_d     = bulletX;
    y_d     = bulletY;
    act_d   = bullet_active;
    shot_d  = 1'b0;
    unique case (state_q)
      READY: begin
        if (spawn_req) begin
          x_d     = playerX + HALF;
          y_d     = playerY + HALF;
          dir_d   = dir_t'(facing);
          act_d   = 1'b1;
          shot_d  = 1'b1;
          state_d = FLYING;
        end
      end
      FLYING: begin
        // Hit outranks motion; retirement keeps the last position on the bus.
        if (hit) begin
          act_d   = 1'b0;
          cd_d    = CD_LOAD;
          state_d = COOLDOWN;
        end else if (frame_tick) begin
          if (step_exit) begin
            act_d   = 1'b0;
            cd_d    = CD_LOAD;
            state_d = COOLDOWN;
          end else begin
            x_d = step_x;
            y_d = step_y;
          end
        end
      end
      COOLDOWN: begin
        if (CD_LOAD == 8'd0) begin
          state_d = READY;
        end else if (frame_tick) begin
          if (cd_q == 8'd0) begin
            state_d = READY;
          end else begin
            cd_d = cd_q - 8'd1;
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= READY;
      dir_q         <= pvp_pkg::UP;
      cd_q          <= '0;
      fire_prev     <= 1'b1;
      bulletX       <= '0;
      bulletY       <= '0;
      bullet_active <= 1'b0;
      shot_fired    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      cd_q          <= cd_d;
      fire_prev     <= fire;
      bulletX       <= x_d;
      bulletY       <= y_d;
      bullet_active <= act_d;
      shot_fired    <= shot_d;
    end
  end

endmodule

// File: tb/tb_pvp_bullet_ctrl.sv
// Directed bench for pvp_bullet_ctrl: expected outputs are queued as each step is driven
// and popped one cycle later when the registered outputs are sampled.
module tb_pvp_bullet_ctrl;
  import pvp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, fire, hit;
  logic [9:0] playerX, playerY;
  logic [1:0] facing;
  logic [9:0] bulletX, bulletY;
  logic       bullet_active, shot_fired;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       shot;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pvp_bullet_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .playerX       (playerX),
    .playerY       (playerY),
    .facing        (facing),
    .hit           (hit),
    .bulletX       (bulletX),
    .bulletY       (bulletY),
    .bullet_active (bullet_active),
    .shot_fired    (shot_fired)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Queue the expected post-edge outputs, clock once, then pop and compare.
  task automatic step(input string tag, input logic [9:0] x, input logic [9:0] y,
                      input logic act, input logic shot);
    exp_t e;
    sb.push_back('{tag, x, y, act, shot});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".x"},    16'(bulletX),       16'(e.x));
    chk({e.tag, ".y"},    16'(bulletY),       16'(e.y));
    chk({e.tag, ".act"},  16'(bullet_active), 16'(e.act));
    chk({e.tag, ".shot"}, 16'(shot_fired),    16'(e.shot));
  endtask

  task automatic cooldown_ticks(input int n, input logic [9:0] x, input logic [9:0] y);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step("cd_tick", x, y, 1'b0, 1'b0);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    fire       = 1'b1;
    frame_tick = 1'b0;
    hit        = 1'b0;
    playerX    = 10'd100;
    playerY    = 10'd200;
    facing     = 2'd1;

    // Reset with fire held high throughout.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_x",     16'(bulletX),       16'd0);
    chk("rst_y",     16'(bulletY),       16'd0);
    chk("rst_act",   16'(bullet_active), 16'd0);
    chk("rst_shot",  16'(shot_fired),    16'd0);
    chk("rst_state", 16'(dut.state_q),   16'(READY));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("held_fire", 10'd0, 10'd0, 1'b0, 1'b0);

    // Spawn right-facing at (100,200) and step three frames.
    fire = 1'b0;
    step("release", 10'd0, 10'd0, 1'b0, 1'b0);
    fire = 1'b1;
    step("spawn", 10'd108, 10'd208, 1'b1, 1'b1);
    fire = 1'b0;
    step("shot_once", 10'd108, 10'd208, 1'b1, 1'b0);
    facing = 2'd3;
    fire   = 1'b1;
    step("fly_fire_ignored", 10'd108, 10'd208, 1'b1, 1'b0);
    fire = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      frame_tick = 1'b1;
      step("move_right", 10'(108 + 4 * i), 10'd208, 1'b1, 1'b0);
      frame_tick = 1'b0;
      step("hold_between", 10'(108 + 4 * i), 10'd208, 1'b1, 1'b0);
    end

    // Hit retires; a fire_rise during cooldown is discarded.
    hit = 1'b1;
    step("hit_retire", 10'd120, 10'd208, 1'b0, 1'b0);
    hit  = 1'b0;
    fire = 1'b1;
    step("cd_fire", 10'd120, 10'd208, 1'b0, 1'b0);
    fire = 1'b0;
    step("cd_release", 10'd120, 10'd208, 1'b0, 1'b0);
    cooldown_ticks(9, 10'd120, 10'd208);
    for (int i = 0; i < 3; i++) step("discarded", 10'd120, 10'd208, 1'b0, 1'b0);
    chk("ready_after_cd", 16'(dut.state_q), 16'(READY));

    // Right-edge exit from X=636, then nine frames before another spawn is possible.
    playerX = 10'd628; playerY = 10'd100; facing = 2'd1;
    fire = 1'b1;
    step("spawn_r", 10'd636, 10'd108, 1'b1, 1'b1);
    fire = 1'b0;
    step("fly_r", 10'd636, 10'd108, 1'b1, 1'b0);
    frame_tick = 1'b1;
    step("right_exit", 10'd636, 10'd108, 1'b0, 1'b0);
    frame_tick = 1'b0;
    // Next spawn wraps 1019+8 to X=3, left-facing.
    playerX = 10'd1019; playerY = 10'd50; facing = 2'd3;
    for (int k = 1; k <= 9; k++) begin
      frame_tick = 1'b1;
      step("cd9_tick", 10'd636, 10'd108, 1'b0, 1'b0);
      frame_tick = 1'b0;
      fire = 1'b1;
      if (k == 9) step("spawn_after_9", 10'd3, 10'd58, 1'b1, 1'b1);
      else        step("cd9_blocked",   10'd636, 10'd108, 1'b0, 1'b0);
      fire = 1'b0;
      if (k == 9) step("fly_l", 10'd3, 10'd58, 1'b1, 1'b0);
      else        step("cd9_idle", 10'd636, 10'd108, 1'b0, 1'b0);
    end

    // Left-edge exit from X=3 must not wrap.
    frame_tick = 1'b1;
    step("left_exit", 10'd3, 10'd58, 1'b0, 1'b0);
    frame_tick = 1'b0;
    cooldown_ticks(9, 10'd3, 10'd58);

    // Hit and frame_tick together at X=300: hit wins, position held.
    playerX = 10'd292; playerY = 10'd92; facing = 2'd0;
    fire = 1'b1;
    step("spawn_h", 10'd300, 10'd100, 1'b1, 1'b1);
    fire = 1'b0;
    step("fly_h", 10'd300, 10'd100, 1'b1, 1'b0);
    hit = 1'b1; frame_tick = 1'b1;
    step("hit_vs_tick", 10'd300, 10'd100, 1'b0, 1'b0);
    frame_tick = 1'b0;
    chk("hit_state", 16'(dut.state_q), 16'(COOLDOWN));
    step("hit_idle_ignored", 10'd300, 10'd100, 1'b0, 1'b0);
    hit = 1'b0;
    cooldown_ticks(9, 10'd300, 10'd100);
    chk("ready_after_hit", 16'(dut.state_q), 16'(READY));

    // Asynchronous reset mid-flight at (400,100).
    playerX = 10'd392; playerY = 10'd92; facing = 2'd2;
    fire = 1'b1;
    step("spawn_m", 10'd400, 10'd100, 1'b1, 1'b1);
    fire = 1'b0;
    step("fly_m", 10'd400, 10'd100, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_x",    16'(bulletX),       16'd0);
    chk("arst_y",    16'(bulletY),       16'd0);
    chk("arst_act",  16'(bullet_active), 16'd0);
    chk("arst_shot", 16'(shot_fired),    16'd0);
    #2 rst_n = 1'b1;
    step("post_reset_idle", 10'd0, 10'd0, 1'b0, 1'b0);
    chk("post_reset_state", 16'(dut.state_q), 16'(READY));
    fire = 1'b1;
    step("post_reset_spawn", 10'd400, 10'd100, 1'b1, 1'b1);
    fire = 1'b0;
    step("post_reset_fly", 10'd400, 10'd100, 1'b1, 1'b0);

`ifdef PVP_BULLET_AUTOFIRE_EN
    // Held fire re-spawns the cycle after READY returns.
    fire = 1'b1;
    hit  = 1'b1;
    step("af_hit", 10'd400, 10'd100, 1'b0, 1'b0);
    hit = 1'b0;
    cooldown_ticks(9, 10'd400, 10'd100);
    step("af_respawn", 10'd400, 10'd100, 1'b1, 1'b1);
    fire = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
